// File: rtl/mem_resp_pkg.sv
// Shared definitions for the latency memory responder.
//   state_t    : responder FSM states (2 bits)
//   ERR_RDATA  : read data returned with an error response
//   word_idx() : byte address to word index, wrapped to the RAM depth
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_WAIT = 2'd1,
    BUSY     = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hBADC_AB1E;

  // Drops the byte offset and wraps to the RAM depth. word_count must be a power of two.
  function automatic int unsigned word_idx(input logic [31:0] addr, input int unsigned word_count);
    return (addr >> 2) & (word_count - 1);
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port 32-bit RAM with per-byte write enables.
// Ports:
//   clk   : clock
//   en    : access enable for this cycle
//   we    : 1 = write the enabled bytes, 0 = read
//   be    : byte enables for writes
//   idx   : word index
//   wdata : write data
//   rdata : read data, registered, valid the cycle after a read access
// The array is deliberately not reset so it maps onto block RAM.
module mem_resp_ram #(
  parameter int WORD_COUNT = 1024,
  localparam int IDX_W = $clog2(WORD_COUNT)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORD_COUNT];

  // Reads and writes share the port; rdata holds until the next read access.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) begin
            mem[idx][8*k +: 8] <= wdata[8*k +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/latency_mem_responder.sv
// Memory-side responder for the req/gnt/rvalid protocol, with programmable grant and
// response latency in front of a byte-write RAM. One transaction is outstanding at a time.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req_i      : request valid
//   addr_i     : byte address
//   wdata_i    : write data
//   we_i       : 1 = write, 0 = read
//   be_i       : byte enables (writes)
//   gnt_o      : request accepted this cycle (combinational)
//   rvalid_o   : one-cycle response pulse
//   rdata_o    : read data, held until the next response
//   error_o    : response error, qualified by rvalid_o
// Optional feature: define MEM_RESP_ADDR_CHECK_EN to reject misaligned or out-of-range
// addresses with an error response. Without it the address wraps and error_o stays 0.
module latency_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WORD_COUNT     = 1024,
  parameter int GNT_LATENCY    = 0,
  parameter int RVALID_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        error_o
);

  localparam int IDX_W = $clog2(WORD_COUNT);

  state_t           state;
  state_t           next_state;
  logic [15:0]      gcnt;
  logic [3:0]       rcnt;
  logic             pend_we;
  logic             pend_err;
  logic             req_err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      ram_rdata;

  assign idx = IDX_W'(word_idx(addr_i, WORD_COUNT));

`ifdef MEM_RESP_ADDR_CHECK_EN
  // Comparing the word address avoids overflow of WORD_COUNT*4 at large depths.
  assign req_err = (addr_i[1:0] != 2'b00) || ({2'b00, addr_i[31:2]} >= 32'(WORD_COUNT));
`else
  assign req_err = 1'b0;
`endif

  // RAM is touched only in the grant cycle; erroneous requests never reach it.
  mem_resp_ram #(
    .WORD_COUNT(WORD_COUNT)
  ) u_ram (
    .clk  (clk),
    .en   (gnt_o && !req_err),
    .we   (we_i),
    .be   (be_i),
    .idx  (idx),
    .wdata(wdata_i),
    .rdata(ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A request seen in BUSY or RESP (the initiator holding req one cycle
  // past the grant) is ignored, so it cannot start a second transaction.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req_i) begin
          next_state = (GNT_LATENCY == 0) ? BUSY : GNT_WAIT;
        end
      end
      GNT_WAIT: begin
        if (!req_i) begin
          next_state = IDLE;
        end else if (gcnt == 16'd1) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (rcnt == 4'd1) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grant output, combinational from state and req_i.
  always_comb begin
    gnt_o = 1'b0;
    unique case (state)
      IDLE:     gnt_o = req_i && (GNT_LATENCY == 0);
      GNT_WAIT: gnt_o = req_i && (gcnt == 16'd1);
      BUSY:     gnt_o = 1'b0;
      RESP:     gnt_o = 1'b0;
    endcase
  end

  // Latency counters, captured request attributes and the registered response.
  // The response is loaded on the BUSY->RESP edge, which is never earlier than the
  // grant+1 edge, so the registered RAM output is already valid there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt     <= '0;
      rcnt     <= '0;
      pend_we  <= 1'b0;
      pend_err <= 1'b0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      error_o  <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;

      if (state == IDLE && req_i && !gnt_o) begin
        gcnt <= 16'(GNT_LATENCY);
      end else if (state == GNT_WAIT && req_i) begin
        gcnt <= gcnt - 16'd1;
      end

      if (gnt_o) begin
        rcnt     <= 4'(RVALID_LATENCY);
        pend_we  <= we_i;
        pend_err <= req_err;
      end else if (state == BUSY) begin
        rcnt <= rcnt - 4'd1;
      end

      if (state == BUSY && next_state == RESP) begin
        rvalid_o <= 1'b1;
        error_o  <= pend_err;
        if (pend_err) begin
          rdata_o <= ERR_RDATA;
        end else if (!pend_we) begin
          rdata_o <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_latency_mem_responder.sv
// Self-checking bench for latency_mem_responder.
// dut0 uses default latencies, dut1 uses GNT_LATENCY=3, RVALID_LATENCY=4. Both share the
// address/data inputs and reset but have separate request lines. Inputs are driven and
// outputs sampled on the falling edge; cyc counts rising edges.
// With MEM_RESP_ADDR_CHECK_EN defined the error responses are checked, otherwise the
// address wrap-around is checked.
module tb_latency_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic        gnt0, rvalid0, error0;
  logic        gnt1, rvalid1, error1;
  logic [31:0] rdata0, rdata1;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  // Expected contents of the words touched by the random test (base 0x400).
  logic [31:0] model [16];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  latency_mem_responder #(
    .WORD_COUNT(1024), .GNT_LATENCY(0), .RVALID_LATENCY(1)
  ) dut0 (
    .clk(clk), .reset(reset), .req_i(req0), .addr_i(addr), .wdata_i(wdata), .we_i(we),
    .be_i(be), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .error_o(error0)
  );

  latency_mem_responder #(
    .WORD_COUNT(1024), .GNT_LATENCY(3), .RVALID_LATENCY(4)
  ) dut1 (
    .clk(clk), .reset(reset), .req_i(req1), .addr_i(addr), .wdata_i(wdata), .we_i(we),
    .be_i(be), .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1), .error_o(error1)
  );

  // Byte-masked merge of new data into an old word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  // Runs one transaction on dut<sel>. Latencies are measured from the request cycle;
  // -1 means the event never came within the cycle budget. hold_extra keeps req high
  // that many cycles past the grant. xgnt counts grants seen while req was still held.
  task automatic txn(input bit sel, input logic [31:0] a, input logic [31:0] wd, input bit w,
                     input logic [3:0] b, input int hold_extra,
                     output logic [31:0] rd, output logic er, output int glat,
                     output int rlat, output int nrv, output int xgnt);
    int t0, tg;
    rd = '0; er = 1'b0; glat = -1; rlat = -1; nrv = 0; xgnt = 0;
    @(negedge clk);
    addr = a; wdata = wd; we = w; be = b;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (sel ? gnt1 : gnt0) begin
        glat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    if (glat < 0) begin
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    tg = cyc;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (cyc - tg > hold_extra) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      #1;
      if ((sel ? req1 : req0) && (sel ? gnt1 : gnt0)) xgnt++;
      if (sel ? rvalid1 : rvalid0) begin
        nrv++;
        if (rlat < 0) begin
          rlat = cyc - t0;
          rd = sel ? rdata1 : rdata0;
          er = sel ? error1 : error0;
        end
      end
      if (rlat >= 0 && cyc - t0 >= rlat + 3) break;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    total++; if (gnt0 !== 1'b0) $display("[TB] FAIL reset_gnt0: got %b expected 0", gnt0); else passed++;
    total++; if (rvalid0 !== 1'b0) $display("[TB] FAIL reset_rvalid0: got %b expected 0", rvalid0); else passed++;
    total++; if (rdata0 !== 32'h0) $display("[TB] FAIL reset_rdata0: got %h expected 0", rdata0); else passed++;
    total++; if (error0 !== 1'b0) $display("[TB] FAIL reset_error0: got %b expected 0", error0); else passed++;
    total++; if (rvalid1 !== 1'b0) $display("[TB] FAIL reset_rvalid1: got %b expected 0", rvalid1); else passed++;
    total++; if (rdata1 !== 32'h0) $display("[TB] FAIL reset_rdata1: got %h expected 0", rdata1); else passed++;
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd; logic er; int gl, rl, nrv, xg;
    txn(0, 32'h100, 32'hDEADBEEF, 1, 4'hF, 0, rd, er, gl, rl, nrv, xg);
    total++; if (rl !== 2) $display("[TB] FAIL wr_rlat: got %0d expected 2", rl); else passed++;
    txn(0, 32'h100, 32'h0, 0, 4'h0, 0, rd, er, gl, rl, nrv, xg);
    total++; if (gl !== 0) $display("[TB] FAIL rd_glat: got %0d expected 0", gl); else passed++;
    total++; if (rl !== 2) $display("[TB] FAIL rd_rlat: got %0d expected 2", rl); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("[TB] FAIL rd_data: got %h expected DEADBEEF", rd); else passed++;
    total++; if (er !== 1'b0) $display("[TB] FAIL rd_error: got %b expected 0", er); else passed++;
    txn(0, 32'h100, 32'h11223344, 1, 4'b0101, 0, rd, er, gl, rl, nrv, xg);
    total++; if (rd !== 32'hDEADBEEF) $display("[TB] FAIL wr_keeps_rdata: got %h expected DEADBEEF", rd); else passed++;
    txn(0, 32'h100, 32'h0, 0, 4'h0, 0, rd, er, gl, rl, nrv, xg);
    total++; if (rd !== 32'hDE22BE44) $display("[TB] FAIL be_merge: got %h expected DE22BE44", rd); else passed++;
    last_rdata = 32'hDE22BE44;
  endtask

  task automatic test_random;
    logic [31:0] rd, exp_rd, wd; logic er; int gl, rl, nrv, xg, i, hold; bit w; logic [3:0] b;
    for (int k = 0; k < 16; k++) begin
      model[k] = $urandom;
      txn(0, 32'h400 + 32'(k * 4), model[k], 1, 4'hF, 0, rd, er, gl, rl, nrv, xg);
    end
    for (int n = 0; n < 30; n++) begin
      i = $urandom_range(0, 15);
      w = 1'($urandom_range(0, 1));
      b = 4'($urandom);
      wd = $urandom;
      hold = $urandom_range(0, 1);
      txn(0, 32'h400 + 32'(i * 4), wd, w, b, hold, rd, er, gl, rl, nrv, xg);
      if (w) begin
        model[i] = merge(model[i], wd, b);
        exp_rd = last_rdata;
      end else begin
        exp_rd = model[i];
        last_rdata = model[i];
      end
      total++; if (gl !== 0) $display("[TB] FAIL rand_glat[%0d]: got %0d expected 0", n, gl); else passed++;
      total++; if (rl !== 2) $display("[TB] FAIL rand_rlat[%0d]: got %0d expected 2", n, rl); else passed++;
      total++; if (nrv !== 1) $display("[TB] FAIL rand_nrvalid[%0d]: got %0d expected 1", n, nrv); else passed++;
      total++; if (xg !== 0) $display("[TB] FAIL rand_extra_gnt[%0d]: got %0d expected 0", n, xg); else passed++;
      total++; if (rd !== exp_rd) $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", n, rd, exp_rd); else passed++;
      total++; if (er !== 1'b0) $display("[TB] FAIL rand_error[%0d]: got %b expected 0", n, er); else passed++;
    end
  endtask

  // Request held continuously: grants repeat every GNT+RVALID+2 = 3 cycles.
  task automatic test_back_to_back;
    logic [8:0] gseen, rseen, gexp, rexp;
    @(negedge clk);
    addr = 32'h100; we = 1'b0; be = 4'h0; req0 = 1'b1;
    for (int o = 0; o < 9; o++) begin
      if (o > 0) @(negedge clk);
      #1;
      gseen[o] = gnt0;
      rseen[o] = rvalid0;
      gexp[o] = (o % 3 == 0);
      rexp[o] = (o % 3 == 2);
      if (rvalid0) begin
        total++;
        if (rdata0 !== 32'hDE22BE44) $display("[TB] FAIL b2b_rdata[%0d]: got %h expected DE22BE44", o, rdata0);
        else passed++;
      end
    end
    req0 = 1'b0;
    total++; if (gseen !== gexp) $display("[TB] FAIL b2b_gnt_pattern: got %b expected %b", gseen, gexp); else passed++;
    total++; if (rseen !== rexp) $display("[TB] FAIL b2b_rvalid_pattern: got %b expected %b", rseen, rexp); else passed++;
  endtask

  task automatic test_latency;
    logic [31:0] rd; logic er; int gl, rl, nrv, xg, seen;
    txn(1, 32'h40, 32'hAAAA5555, 1, 4'hF, 1, rd, er, gl, rl, nrv, xg);
    total++; if (gl !== 3) $display("[TB] FAIL lat_wr_glat: got %0d expected 3", gl); else passed++;
    total++; if (rl !== 8) $display("[TB] FAIL lat_wr_rlat: got %0d expected 8", rl); else passed++;
    total++; if (nrv !== 1) $display("[TB] FAIL lat_wr_nrvalid: got %0d expected 1", nrv); else passed++;
    total++; if (xg !== 0) $display("[TB] FAIL lat_wr_extra_gnt: got %0d expected 0", xg); else passed++;
    // Request dropped after one cycle: no grant, no write.
    @(negedge clk);
    addr = 32'h40; wdata = 32'h12345678; we = 1'b1; be = 4'hF; req1 = 1'b1;
    seen = 0;
    for (int o = 0; o < 8; o++) begin
      if (o == 1) req1 = 1'b0;
      #1;
      if (gnt1 || rvalid1) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) $display("[TB] FAIL drop_no_gnt: got %0d events expected 0", seen); else passed++;
    txn(1, 32'h40, 32'h0, 0, 4'h0, 0, rd, er, gl, rl, nrv, xg);
    total++; if (gl !== 3) $display("[TB] FAIL lat_rd_glat: got %0d expected 3", gl); else passed++;
    total++; if (rl !== 8) $display("[TB] FAIL lat_rd_rlat: got %0d expected 8", rl); else passed++;
    total++; if (rd !== 32'hAAAA5555) $display("[TB] FAIL drop_no_write: got %h expected AAAA5555", rd); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int gl, rl, nrv, xg, seen;
    @(negedge clk);
    addr = 32'h200; wdata = 32'hCAFEF00D; we = 1'b1; be = 4'hF; req0 = 1'b1;
    #1;
    total++; if (gnt0 !== 1'b1) $display("[TB] FAIL rstmid_gnt: got %b expected 1", gnt0); else passed++;
    @(negedge clk);
    req0 = 1'b0; reset = 1'b1;
    @(negedge clk); #1;
    total++; if (rvalid0 !== 1'b0) $display("[TB] FAIL rstmid_rvalid: got %b expected 0", rvalid0); else passed++;
    total++; if (rdata0 !== 32'h0) $display("[TB] FAIL rstmid_rdata: got %h expected 0", rdata0); else passed++;
    total++; if (error0 !== 1'b0) $display("[TB] FAIL rstmid_error: got %b expected 0", error0); else passed++;
    reset = 1'b0;
    seen = 0;
    for (int o = 0; o < 6; o++) begin
      @(negedge clk); #1;
      if (rvalid0) seen++;
    end
    total++; if (seen !== 0) $display("[TB] FAIL rstmid_no_rvalid: got %0d expected 0", seen); else passed++;
    txn(0, 32'h200, 32'h0, 0, 4'h0, 0, rd, er, gl, rl, nrv, xg);
    total++; if (rd !== 32'hCAFEF00D) $display("[TB] FAIL rstmid_write_kept: got %h expected CAFEF00D", rd); else passed++;
  endtask

`ifdef MEM_RESP_ADDR_CHECK_EN
  task automatic test_addr_check;
    logic [31:0] rd; logic er; int gl, rl, nrv, xg;
    txn(0, 32'h0, 32'h0BADF00D, 1, 4'hF, 0, rd, er, gl, rl, nrv, xg);
    txn(0, 32'h1002, 32'h0, 0, 4'h0, 0, rd, er, gl, rl, nrv, xg);
    total++; if (gl !== 0) $display("[TB] FAIL err_rd_glat: got %0d expected 0", gl); else passed++;
    total++; if (er !== 1'b1) $display("[TB] FAIL err_rd_error: got %b expected 1", er); else passed++;
    total++; if (rd !== 32'hBADCAB1E) $display("[TB] FAIL err_rd_rdata: got %h expected BADCAB1E", rd); else passed++;
    txn(0, 32'h1000, 32'h77777777, 1, 4'hF, 0, rd, er, gl, rl, nrv, xg);
    total++; if (er !== 1'b1) $display("[TB] FAIL err_wr_error: got %b expected 1", er); else passed++;
    total++; if (rd !== 32'hBADCAB1E) $display("[TB] FAIL err_wr_rdata: got %h expected BADCAB1E", rd); else passed++;
    txn(0, 32'h101, 32'h66666666, 1, 4'hF, 0, rd, er, gl, rl, nrv, xg);
    total++; if (er !== 1'b1) $display("[TB] FAIL err_misalign_error: got %b expected 1", er); else passed++;
    txn(0, 32'h0, 32'h0, 0, 4'h0, 0, rd, er, gl, rl, nrv, xg);
    total++; if (rd !== 32'h0BADF00D) $display("[TB] FAIL err_word0_unchanged: got %h expected 0BADF00D", rd); else passed++;
    total++; if (er !== 1'b0) $display("[TB] FAIL err_clear: got %b expected 0", er); else passed++;
    txn(0, 32'h100, 32'h0, 0, 4'h0, 0, rd, er, gl, rl, nrv, xg);
    total++; if (rd !== 32'hDE22BE44) $display("[TB] FAIL err_word64_unchanged: got %h expected DE22BE44", rd); else passed++;
  endtask
`else
  task automatic test_alias;
    logic [31:0] rd; logic er; int gl, rl, nrv, xg;
    txn(0, 32'h0, 32'h0BADF00D, 1, 4'hF, 0, rd, er, gl, rl, nrv, xg);
    txn(0, 32'h1008, 32'h600DCAFE, 1, 4'hF, 0, rd, er, gl, rl, nrv, xg);
    total++; if (er !== 1'b0) $display("[TB] FAIL alias_wr_error: got %b expected 0", er); else passed++;
    txn(0, 32'h8, 32'h0, 0, 4'h0, 0, rd, er, gl, rl, nrv, xg);
    total++; if (rd !== 32'h600DCAFE) $display("[TB] FAIL alias_word2: got %h expected 600DCAFE", rd); else passed++;
    txn(0, 32'h1002, 32'h0, 0, 4'h0, 0, rd, er, gl, rl, nrv, xg);
    total++; if (rd !== 32'h0BADF00D) $display("[TB] FAIL alias_word0: got %h expected 0BADF00D", rd); else passed++;
    total++; if (er !== 1'b0) $display("[TB] FAIL alias_rd_error: got %b expected 0", er); else passed++;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_byte_enable();
    test_random();
    test_back_to_back();
    test_latency();
    test_reset_mid();
`ifdef MEM_RESP_ADDR_CHECK_EN
    test_addr_check();
`else
    test_alias();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
